chip8_draw_engine: RTL and testbench

CHIP8_DRAW_ENGINE -- requirements
Module: chip8_draw_engine

---
 rtl/chip8_draw_engine.sv | 208 ++++++++++++++++++++
 tb/tb_chip8_draw_engine.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/chip8_draw_engine.sv
// chip8_draw_engine: CHIP-8 style sprite blitter and screen clear engine.
// Reads sprite bytes from a byte memory, XORs each into a 64-pixel video
// row (bit 0 = leftmost pixel) with horizontal and vertical wrap, and reports
// pixel collisions.
// Ports:
//   SYS_CLK, CPU_RESETN            clock, async active-low reset
//   start_draw, start_clear        single-cycle command strobes (IDLE only)
//   x, y, n, i                     sprite origin, height, base address
//   mem_rd, mem_addr, mem_rdata    sprite memory read port (1-cycle latency)
//   vid_rd, vid_we, vid_row,
//   vid_wdata, vid_rdata           video row port (1-cycle read latency)
//   busy, done, collision          status
module chip8_draw_engine (
    input  logic        SYS_CLK,
    input  logic        CPU_RESETN,
    input  logic        start_draw,
    input  logic        start_clear,
    input  logic [7:0]  x,
    input  logic [7:0]  y,
    input  logic [3:0]  n,
    input  logic [11:0] i,
    output logic        mem_rd,
    output logic [11:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    output logic        vid_rd,
    output logic        vid_we,
    output logic [4:0]  vid_row,
    output logic [63:0] vid_wdata,
    input  logic [63:0] vid_rdata,
    output logic        busy,
    output logic        done,
    output logic        collision
);

    localparam int unsigned ROW_W  = 64;
    localparam int unsigned ROWS   = 32;
    localparam int unsigned COL_W  = 6;
    localparam int unsigned RIDX_W = 5;
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_FETCH,
        ST_MERGE,
        ST_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [COL_W-1:0]    x_q, x_d;
    logic [RIDX_W-1:0]   y_q, y_d;
    logic [CNT_W-1:0]    n_q, n_d;
    logic [ADDR_W-1:0]   i_q, i_d;
    logic [CNT_W-1:0]    k_q, k_d;
    logic [RIDX_W-1:0]   clr_row_q, clr_row_d;
    logic                collision_q, collision_d;

    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                vid_rd_q, vid_rd_d;
    logic                vid_we_q, vid_we_d;
    logic [RIDX_W-1:0]   vid_row_q, vid_row_d;

    logic [ROW_W-1:0]    mask;
    logic                hit;

    // Only the low bits of x and y matter: origin is taken modulo screen size.
    logic unused_bits;
    assign unused_bits = ^{x[7:6], y[7:5]};

    // Sprite byte placed at column x (MSB) through x+7 (LSB), wrapping at 64.
    always_comb begin
        logic [COL_W-1:0] col;
        mask = '0;
        col  = '0;
        for (int b = 0; b < int'(BYTE_W); b++) begin
            col       = x_q + COL_W'(b);
            mask[col] = mem_rdata[3'(7 - b)];
        end
    end

    assign hit       = |(vid_rdata & mask);
    // Write data depends on this cycle's read data, so it cannot be registered
    // without breaking the two-cycle-per-row budget.
    assign vid_wdata = (state_q == ST_MERGE) ? (vid_rdata ^ mask) : '0;

    // Next-state and next-output logic; outputs are registered from the
    // decoded next state so they line up with the state they belong to.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        n_d         = n_q;
        i_d         = i_q;
        k_d         = k_q;
        clr_row_d   = clr_row_q;
        collision_d = collision_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start_clear) begin
                    state_d     = ST_CLEAR;
                    clr_row_d   = '0;
                    collision_d = 1'b0;
                end else if (start_draw) begin
                    x_d         = x[COL_W-1:0];
                    y_d         = y[RIDX_W-1:0];
                    n_d         = n;
                    i_d         = i;
                    k_d         = '0;
                    collision_d = 1'b0;
                    state_d     = (n == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_CLEAR: begin
                if (clr_row_q == RIDX_W'(ROWS - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    clr_row_d = clr_row_q + RIDX_W'(1);
                end
            end
            ST_FETCH: begin
                state_d = ST_MERGE;
            end
            ST_MERGE: begin
                if (hit) begin
                    collision_d = 1'b1;
                end
                if ((5'(k_q) + 5'd1) < 5'(n_q)) begin
                    k_d     = k_q + CNT_W'(1);
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
        mem_rd_d   = (state_d == ST_FETCH);
        vid_rd_d   = (state_d == ST_FETCH);
        vid_we_d   = (state_d == ST_CLEAR) || (state_d == ST_MERGE);
        mem_addr_d = (state_d == ST_FETCH) ? (i_d + ADDR_W'(k_d)) : '0;

        unique case (state_d)
            ST_CLEAR:           vid_row_d = clr_row_d;
            ST_FETCH, ST_MERGE: vid_row_d = y_d + RIDX_W'(k_d);
            default:            vid_row_d = '0;
        endcase
    end

    // State, command context and registered outputs.
    always_ff @(posedge SYS_CLK or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            n_q         <= '0;
            i_q         <= '0;
            k_q         <= '0;
            clr_row_q   <= '0;
            collision_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_addr_q  <= '0;
            vid_rd_q    <= 1'b0;
            vid_we_q    <= 1'b0;
            vid_row_q   <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            n_q         <= n_d;
            i_q         <= i_d;
            k_q         <= k_d;
            clr_row_q   <= clr_row_d;
            collision_q <= collision_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mem_rd_q    <= mem_rd_d;
            mem_addr_q  <= mem_addr_d;
            vid_rd_q    <= vid_rd_d;
            vid_we_q    <= vid_we_d;
            vid_row_q   <= vid_row_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign collision = collision_q;
    assign mem_rd    = mem_rd_q;
    assign mem_addr  = mem_addr_q;
    assign vid_rd    = vid_rd_q;
    assign vid_we    = vid_we_q;
    assign vid_row   = vid_row_q;

endmodule

// File: tb/tb_chip8_draw_engine.sv
// tb_chip8_draw_engine: scoreboard bench for chip8_draw_engine.
// Expected memory reads and video writes are pushed when a command is issued
// and popped as the DUT performs them; video and sprite memories live here.
module tb_chip8_draw_engine;

    logic        SYS_CLK = 1'b0;
    logic        CPU_RESETN;
    logic        start_draw, start_clear;
    logic [7:0]  x, y;
    logic [3:0]  n;
    logic [11:0] i;
    logic        mem_rd;
    logic [11:0] mem_addr;
    logic [7:0]  mem_rdata;
    logic        vid_rd, vid_we;
    logic [4:0]  vid_row;
    logic [63:0] vid_wdata, vid_rdata;
    logic        busy, done, collision;

    always #5 SYS_CLK = ~SYS_CLK;

    chip8_draw_engine dut (
        .SYS_CLK     (SYS_CLK),
        .CPU_RESETN  (CPU_RESETN),
        .start_draw  (start_draw),
        .start_clear (start_clear),
        .x           (x),
        .y           (y),
        .n           (n),
        .i           (i),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_rdata   (mem_rdata),
        .vid_rd      (vid_rd),
        .vid_we      (vid_we),
        .vid_row     (vid_row),
        .vid_wdata   (vid_wdata),
        .vid_rdata   (vid_rdata),
        .busy        (busy),
        .done        (done),
        .collision   (collision)
    );

    typedef struct {
        logic [4:0]  row;
        logic [63:0] data;
    } wr_t;

    typedef struct {
        logic [11:0] addr;
        logic [4:0]  row;
    } rd_t;

    wr_t         wq[$];
    rd_t         rq[$];
    logic [7:0]  mem [4096];
    logic [63:0] scr [32];
    logic [63:0] model_scr [32];
    logic        exp_col;
    int          m_x, m_y, m_i;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Sprite and video memories seen by the DUT.
    always @(posedge SYS_CLK) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
        if (vid_rd) vid_rdata <= scr[vid_row];
        if (vid_we) scr[vid_row] <= vid_wdata;
    end

    // Scoreboard monitor.
    always @(negedge SYS_CLK) begin
        if (CPU_RESETN) begin
            if (vid_we) begin
                chk("rd_we_excl", 64'(vid_rd), 64'd0);
                chk("wr_expected", 64'(wq.size() != 0), 64'd1);
                if (wq.size() != 0) begin
                    wr_t e;
                    e = wq.pop_front();
                    chk("wr_row", 64'(vid_row), 64'(e.row));
                    chk("wr_data", vid_wdata, e.data);
                end
            end
            if (mem_rd) begin
                chk("fetch_vid_rd", 64'(vid_rd), 64'd1);
                chk("rd_expected", 64'(rq.size() != 0), 64'd1);
                if (rq.size() != 0) begin
                    rd_t r;
                    r = rq.pop_front();
                    chk("rd_addr", 64'(mem_addr), 64'(r.addr));
                    chk("rd_row", 64'(vid_row), 64'(r.row));
                end
            end
        end
    end

    // Model of one sprite row: expected fetch and (optionally) expected write.
    task automatic model_row(input int k, input bit do_wr);
        logic [4:0]  row;
        logic [11:0] addr;
        logic [7:0]  b;
        logic [63:0] m;
        row  = 5'((m_y + k) % 32);
        addr = 12'((m_i + k) % 4096);
        b    = mem[addr];
        m    = '0;
        for (int c = 0; c < 64; c++) begin
            int p;
            p = (c - m_x + 64) % 64;
            if (p < 8) m[c] = b[7 - p];
        end
        rq.push_back('{addr: addr, row: row});
        if (do_wr) begin
            if ((model_scr[row] & m) != '0) exp_col = 1'b1;
            model_scr[row] = model_scr[row] ^ m;
            wq.push_back('{row: row, data: model_scr[row]});
        end
    endtask

    task automatic model_cmd(input logic clr, input logic drw, input logic [7:0] xx,
                             input logic [7:0] yy, input logic [3:0] nn, input logic [11:0] ii);
        if (clr) begin
            exp_col = 1'b0;
            for (int r = 0; r < 32; r++) begin
                model_scr[r] = '0;
                wq.push_back('{row: 5'(r), data: 64'd0});
            end
        end else if (drw) begin
            exp_col = 1'b0;
            m_x = int'(xx) % 64;
            m_y = int'(yy) % 32;
            m_i = int'(ii);
            for (int k = 0; k < int'(nn); k++) model_row(k, 1'b1);
        end
    endtask

    task automatic run_cmd(input logic clr, input logic drw, input logic [7:0] xx,
                           input logic [7:0] yy, input logic [3:0] nn, input logic [11:0] ii,
                           input int exp_cyc, input bit poke);
        int cyc;
        model_cmd(clr, drw, xx, yy, nn, ii);
        @(negedge SYS_CLK);
        start_clear = clr;
        start_draw  = drw;
        x = xx; y = yy; n = nn; i = ii;
        @(negedge SYS_CLK);
        start_clear = 1'b0;
        start_draw  = 1'b0;
        cyc = 1;
        chk("busy_after_accept", 64'(busy), 64'd1);
        while (!done && cyc < 100) begin
            start_draw  = poke && (cyc == 3);
            start_clear = poke && (cyc == 3);
            x = 8'd9; y = 8'd3; n = 4'd5; i = 12'h123;
            @(negedge SYS_CLK);
            cyc++;
        end
        start_draw  = 1'b0;
        start_clear = 1'b0;
        chk("done_cycle", 64'(cyc), 64'(exp_cyc));
        @(negedge SYS_CLK);
        chk("done_one_cycle", 64'(done), 64'd0);
        chk("idle_not_busy", 64'(busy), 64'd0);
        chk("collision", 64'(collision), 64'(exp_col));
        chk("wq_drained", 64'(wq.size()), 64'd0);
        chk("rq_drained", 64'(rq.size()), 64'd0);
    endtask

    initial begin
        for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom);
        for (int r = 0; r < 32; r++) model_scr[r] = '0;
        mem[12'h050] = 8'hF0;
        mem[12'h051] = 8'h90;
        mem[12'h300] = 8'hFF;
        mem[12'h301] = 8'hFF;
        exp_col     = 1'b0;
        CPU_RESETN  = 1'b0;
        start_draw  = 1'b0;
        start_clear = 1'b0;
        x = '0; y = '0; n = '0; i = '0;

        repeat (2) @(negedge SYS_CLK);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_collision", 64'(collision), 64'd0);
        chk("rst_ports", 64'({mem_rd, vid_rd, vid_we}), 64'd0);
        chk("rst_addr_row", 64'({mem_addr, vid_row}), 64'd0);
        chk("rst_wdata", vid_wdata, 64'd0);
        CPU_RESETN = 1'b1;

        // Clear, then the two-row example sprite, then redraw it.
        run_cmd(1'b1, 1'b0, 8'd0, 8'd0, 4'd0, 12'h000, 33, 1'b0);
        run_cmd(1'b0, 1'b1, 8'd0, 8'd0, 4'd2, 12'h050, 5, 1'b0);
        chk("ex_row0", scr[0], 64'h0000_0000_0000_000F);
        chk("ex_row1", scr[1], 64'h0000_0000_0000_0009);
        run_cmd(1'b0, 1'b1, 8'd0, 8'd0, 4'd2, 12'h050, 5, 1'b0);
        chk("redraw_row0", scr[0], 64'd0);
        chk("redraw_row1", scr[1], 64'd0);

        // Horizontal and vertical wrap.
        run_cmd(1'b0, 1'b1, 8'd62, 8'd31, 4'd2, 12'h300, 5, 1'b0);
        chk("wrap_row31", scr[31], 64'hC000_0000_0000_003F);
        chk("wrap_row0", scr[0], 64'hC000_0000_0000_003F);

        // Contention: clear beats draw, strobes while busy are ignored, n=0.
        run_cmd(1'b1, 1'b1, 8'd4, 8'd4, 4'd3, 12'h050, 33, 1'b1);
        run_cmd(1'b0, 1'b1, 8'd5, 8'd6, 4'd0, 12'h050, 1, 1'b0);
        run_cmd(1'b0, 1'b1, 8'd70, 8'd40, 4'd3, 12'hFFE, 7, 1'b1);

        // Reset during MERGE of row 1 aborts the command.
        m_x = 10; m_y = 12; m_i = 'h200;
        exp_col = 1'b0;
        model_row(0, 1'b1);
        model_row(1, 1'b0);
        @(negedge SYS_CLK);
        start_draw = 1'b1;
        x = 8'd10; y = 8'd12; n = 4'd4; i = 12'h200;
        @(negedge SYS_CLK);
        start_draw = 1'b0;
        repeat (2) @(negedge SYS_CLK);
        @(posedge SYS_CLK);
        #2;
        chk("merge_r1_we", 64'(vid_we), 64'd1);
        CPU_RESETN = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_ports", 64'({mem_rd, vid_rd, vid_we, done}), 64'd0);
        chk("abort_wdata", vid_wdata, 64'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge SYS_CLK);
            chk("abort_no_done", 64'(done), 64'd0);
        end
        CPU_RESETN = 1'b1;
        chk("abort_wq", 64'(wq.size()), 64'd0);
        chk("abort_rq", 64'(rq.size()), 64'd0);
        run_cmd(1'b0, 1'b1, 8'd10, 8'd12, 4'd2, 12'h050, 5, 1'b0);

        // Random sprites over accumulated content.
        for (int t = 0; t < 6; t++) begin
            logic [3:0] rn;
            rn = 4'($urandom_range(1, 15));
            run_cmd(1'b0, 1'b1, 8'($urandom), 8'($urandom), rn, 12'($urandom), 2 * int'(rn) + 1, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
